vga_timing_gen: RTL and testbench

Parametrised horizontal/vertical video timing generator for the VGA controller. It replaces the horizontal-only sync counter with a combined raster counter pair. It produces hsync, vsync, display-active, line-start and frame-start strobes, plus the current pixel coordinates, and it supports configurable sync polarity. It sits between the pixel clock source and the pixel/framebuffer fetch logic.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_timing_if.sv | 35 +++
 rtl/vga_axis_counter.sv | 73 +++++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default raster timings, counter width and the shared sync-flag bundle
// for the VGA timing generator and its downstream consumers.
package vga_timing_pkg;

  // Default counter width; 2^11 = 2048 covers both totals below.
  localparam int unsigned CNT_W_DEFAULT = 11;

  // 640x480 @ 60 Hz, 800 x 525 total.
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  // 800x600 @ 72 Hz, 1040 x 666 total.
  localparam int unsigned VGA800_H_ACTIVE = 800;
  localparam int unsigned VGA800_H_FP     = 56;
  localparam int unsigned VGA800_H_SYNC   = 120;
  localparam int unsigned VGA800_H_BP     = 64;
  localparam int unsigned VGA800_V_ACTIVE = 600;
  localparam int unsigned VGA800_V_FP     = 37;
  localparam int unsigned VGA800_V_SYNC   = 6;
  localparam int unsigned VGA800_V_BP     = 23;

  // Sync and strobe flags for one pixel position.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic disp_active;
    logic newline;
    logic newframe;
  } vga_sync_t;

  // Length of one axis period in pixels or lines.
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster position and sync/strobe bundle from the timing generator to the
// pixel fetch logic. master drives, slave observes.
interface vga_timing_if import vga_timing_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

  logic [CNT_W-1:0] xpos;
  logic [CNT_W-1:0] ypos;
  logic             hsync;
  logic             vsync;
  logic             disp_active;
  logic             newline;
  logic             newframe;

  modport master (
    output xpos,
    output ypos,
    output hsync,
    output vsync,
    output disp_active,
    output newline,
    output newframe
  );

  modport slave (
    input xpos,
    input ypos,
    input hsync,
    input vsync,
    input disp_active,
    input newline,
    input newframe
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one wrapping raster axis (active / front porch / sync / back porch).
// The count and the sync level are registered; active and zero are exported as decodes of
// the next count so the parent can register them in step with the count.
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int unsigned ACTIVE   = VGA800_H_ACTIVE,
  parameter int unsigned FP       = VGA800_H_FP,
  parameter int unsigned SYNC     = VGA800_H_SYNC,
  parameter int unsigned BP       = VGA800_H_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             active_nxt,
  output logic             zero_nxt,
  output logic             sync,
  output logic             wrap
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_len_check
    $fatal(1, "vga_axis_counter: every segment length must be at least 1");
  end

  if (CNT_W < 1 || (CNT_W < 32 && TOTAL > (32'd1 << CNT_W))) begin : g_width_check
    $fatal(1, "vga_axis_counter: CNT_W too narrow for the axis total");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap    = en & at_last;

  // Next position: advance when enabled, wrapping to 0 after the last back-porch slot.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Decode the next position so every registered flag matches the registered count.
  always_comb begin
    active_nxt = (cnt_d < ACT_END);
    zero_nxt   = (cnt_d == '0);
    sync_d     = ((cnt_d >= SYNC_BEG) && (cnt_d < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Reset parks the axis on its last blanking slot so the first edge lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= LAST;
      sync_q <= ~SYNC_POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical raster timing generator. Produces xpos/ypos, hsync,
// vsync, disp_active, newline and newframe, all registered and aligned with the counters.
// Optional macro VGA_TIMING_CE_EN adds a pix_ce pixel clock enable; without it the raster
// advances on every clk edge.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int unsigned H_ACTIVE   = VGA800_H_ACTIVE,
  parameter int unsigned H_FP       = VGA800_H_FP,
  parameter int unsigned H_SYNC     = VGA800_H_SYNC,
  parameter int unsigned H_BP       = VGA800_H_BP,
  parameter int unsigned V_ACTIVE   = VGA800_V_ACTIVE,
  parameter int unsigned V_FP       = VGA800_V_FP,
  parameter int unsigned V_SYNC     = VGA800_V_SYNC,
  parameter int unsigned V_BP       = VGA800_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
`ifdef VGA_TIMING_CE_EN
  input  logic          pix_ce,
`endif
  vga_timing_if.master  vga
);

  logic             h_en;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act_nxt, v_act_nxt;
  logic             h_zero_nxt, v_zero_nxt;
  logic             h_sync, v_sync;
  logic             h_wrap, v_wrap;
  logic             unused_v_wrap;

`ifdef VGA_TIMING_CE_EN
  assign h_en = pix_ce;
`else
  assign h_en = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (H_SYNC_POL),
    .CNT_W    (CNT_W)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .en         (h_en),
    .cnt        (h_cnt),
    .active_nxt (h_act_nxt),
    .zero_nxt   (h_zero_nxt),
    .sync       (h_sync),
    .wrap       (h_wrap)
  );

  // The line counter steps only on the pixel that ends a line.
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (V_SYNC_POL),
    .CNT_W    (CNT_W)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .cnt        (v_cnt),
    .active_nxt (v_act_nxt),
    .zero_nxt   (v_zero_nxt),
    .sync       (v_sync),
    .wrap       (v_wrap)
  );

  assign unused_v_wrap = v_wrap;

  logic disp_active_q, disp_active_d;
  logic newline_q, newline_d;
  logic newframe_q, newframe_d;

  // Combine per-axis next-position decodes into the strobes for the upcoming position.
  always_comb begin
    disp_active_d = h_act_nxt & v_act_nxt;
    newline_d     = h_zero_nxt;
    newframe_d    = h_zero_nxt & v_zero_nxt;
  end

  // Strobe registers; reset values match the parked last-blanking position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_active_q <= 1'b0;
      newline_q     <= 1'b0;
      newframe_q    <= 1'b0;
    end else begin
      disp_active_q <= disp_active_d;
      newline_q     <= newline_d;
      newframe_q    <= newframe_d;
    end
  end

  vga_sync_t flags;

  // Bundle the registered flags for the interface.
  always_comb begin
    flags             = '0;
    flags.hsync       = h_sync;
    flags.vsync       = v_sync;
    flags.disp_active = disp_active_q;
    flags.newline     = newline_q;
    flags.newframe    = newframe_q;
  end

  assign vga.xpos        = h_cnt;
  assign vga.ypos        = v_cnt;
  assign vga.hsync       = flags.hsync;
  assign vga.vsync       = flags.vsync;
  assign vga.disp_active = flags.disp_active;
  assign vga.newline     = flags.newline;
  assign vga.newframe    = flags.newframe;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of three generator instances: the 800x600 defaults,
// 640x480 with active-high syncs, and a tiny 15x8 raster used for whole-frame behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen import vga_timing_pkg::*;;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
`ifdef VGA_TIMING_CE_EN
  logic pix_ce;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  vga_timing_if #(.CNT_W(11)) vga0 ();
  vga_timing_if #(.CNT_W(11)) vga1 ();
  vga_timing_if #(.CNT_W(4))  vga2 ();

  vga_timing_gen dut0 (
    .clk    (clk),
    .rst    (rst_a),
`ifdef VGA_TIMING_CE_EN
    .pix_ce (pix_ce),
`endif
    .vga    (vga0)
  );

  vga_timing_gen #(
    .H_ACTIVE   (VGA640_H_ACTIVE),
    .H_FP       (VGA640_H_FP),
    .H_SYNC     (VGA640_H_SYNC),
    .H_BP       (VGA640_H_BP),
    .V_ACTIVE   (VGA640_V_ACTIVE),
    .V_FP       (VGA640_V_FP),
    .V_SYNC     (VGA640_V_SYNC),
    .V_BP       (VGA640_V_BP),
    .H_SYNC_POL (1'b1),
    .V_SYNC_POL (1'b1),
    .CNT_W      (11)
  ) dut1 (
    .clk    (clk),
    .rst    (rst_a),
`ifdef VGA_TIMING_CE_EN
    .pix_ce (pix_ce),
`endif
    .vga    (vga1)
  );

  // 15 x 8 raster: hsync low for x 10..12, vsync low for y 5..6, active 8 x 4.
  vga_timing_gen #(
    .H_ACTIVE   (8),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (2),
    .V_ACTIVE   (4),
    .V_FP       (1),
    .V_SYNC     (2),
    .V_BP       (1),
    .H_SYNC_POL (1'b0),
    .V_SYNC_POL (1'b0),
    .CNT_W      (4)
  ) dut2 (
    .clk    (clk),
    .rst    (rst_b),
`ifdef VGA_TIMING_CE_EN
    .pix_ce (pix_ce),
`endif
    .vga    (vga2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to negedge number 'target' counted from the last t = 0.
  task automatic step_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int nf_cnt;
    int nl_cnt;
    int vs_low;
    int hs_low;
    int da_cnt;

    rst_a = 1'b1;
    rst_b = 1'b1;
`ifdef VGA_TIMING_CE_EN
    pix_ce = 1'b1;
`endif
    repeat (5) @(negedge clk);

    // Held in reset: last blanking position, syncs deasserted.
    check("rst0_x", vga0.xpos, 1039);
    check("rst0_y", vga0.ypos, 665);
    check("rst0_hs", vga0.hsync, 1);
    check("rst0_vs", vga0.vsync, 1);
    check("rst0_da", vga0.disp_active, 0);
    check("rst0_nl", vga0.newline, 0);
    check("rst0_nf", vga0.newframe, 0);
    check("rst1_x", vga1.xpos, 799);
    check("rst1_y", vga1.ypos, 524);
    check("rst1_hs", vga1.hsync, 0);
    check("rst1_vs", vga1.vsync, 0);
    check("rst2_x", vga2.xpos, 14);
    check("rst2_y", vga2.ypos, 7);

    rst_a = 1'b0;
    @(negedge clk);
    t = 0;
    check("rel0_x", vga0.xpos, 0);
    check("rel0_y", vga0.ypos, 0);
    check("rel0_nl", vga0.newline, 1);
    check("rel0_nf", vga0.newframe, 1);
    check("rel0_da", vga0.disp_active, 1);
    check("rel0_hs", vga0.hsync, 1);
    check("rel0_vs", vga0.vsync, 1);
    check("rel1_nf", vga1.newframe, 1);
    check("rel1_hs", vga1.hsync, 0);
    check("hold2_x", vga2.xpos, 14);

    // Horizontal edges on both full-size rasters.
    step_to(655);  check("h1_655_hs", vga1.hsync, 0);
    step_to(656);  check("h1_656_hs", vga1.hsync, 1);
    step_to(751);  check("h1_751_hs", vga1.hsync, 1);
    step_to(752);  check("h1_752_hs", vga1.hsync, 0);
    step_to(799);
    check("h0_799_da", vga0.disp_active, 1);
    check("h1_799_x", vga1.xpos, 799);
    step_to(800);
    check("h0_800_da", vga0.disp_active, 0);
    check("h1_800_x", vga1.xpos, 0);
    check("h1_800_y", vga1.ypos, 1);
    check("h1_800_nl", vga1.newline, 1);
    check("h1_800_nf", vga1.newframe, 0);
    step_to(855);  check("h0_855_hs", vga0.hsync, 1);
    step_to(856);  check("h0_856_hs", vga0.hsync, 0);
    step_to(975);  check("h0_975_hs", vga0.hsync, 0);
    step_to(976);  check("h0_976_hs", vga0.hsync, 1);
    step_to(1039);
    check("h0_1039_x", vga0.xpos, 1039);
    check("h0_1039_y", vga0.ypos, 0);
    check("h0_1039_nl", vga0.newline, 0);
    step_to(1040);
    check("h0_1040_x", vga0.xpos, 0);
    check("h0_1040_y", vga0.ypos, 1);
    check("h0_1040_nl", vga0.newline, 1);
    check("h0_1040_nf", vga0.newframe, 0);
    check("h0_1040_da", vga0.disp_active, 1);
    check("h0_1040_vs", vga0.vsync, 1);

    // Whole frame on the small raster.
    rst_b = 1'b0;
    @(negedge clk);
    t = 0;
    nf_cnt = 0; nl_cnt = 0; vs_low = 0; hs_low = 0; da_cnt = 0;
    for (int u = 0; u < 120; u++) begin
      step_to(u);
      if (vga2.newframe) nf_cnt++;
      if (vga2.newline) nl_cnt++;
      if (!vga2.vsync) vs_low++;
      if (!vga2.hsync) hs_low++;
      if (vga2.disp_active) da_cnt++;
      case (u)
        0: begin
          check("f2_0_x", vga2.xpos, 0);
          check("f2_0_y", vga2.ypos, 0);
          check("f2_0_nf", vga2.newframe, 1);
        end
        74: begin
          check("f2_74_x", vga2.xpos, 14);
          check("f2_74_y", vga2.ypos, 4);
          check("f2_74_vs", vga2.vsync, 1);
        end
        75: begin
          check("f2_75_x", vga2.xpos, 0);
          check("f2_75_y", vga2.ypos, 5);
          check("f2_75_vs", vga2.vsync, 0);
          check("f2_75_nl", vga2.newline, 1);
        end
        104: check("f2_104_vs", vga2.vsync, 0);
        105: check("f2_105_vs", vga2.vsync, 1);
        119: begin
          check("f2_119_x", vga2.xpos, 14);
          check("f2_119_y", vga2.ypos, 7);
          check("f2_119_nf", vga2.newframe, 0);
        end
        default: ;
      endcase
    end
    check("f2_nf_count", nf_cnt, 1);
    check("f2_nl_count", nl_cnt, 8);
    check("f2_vs_low", vs_low, 30);
    check("f2_hs_low", hs_low, 24);
    check("f2_da_count", da_cnt, 32);
    step_to(120);
    check("f2_120_x", vga2.xpos, 0);
    check("f2_120_y", vga2.ypos, 0);
    check("f2_120_nf", vga2.newframe, 1);

    // Reset inside both sync pulses: outputs drop to reset values without a clock edge.
    step_to(206);
    check("mid_pre_x", vga2.xpos, 11);
    check("mid_pre_y", vga2.ypos, 5);
    check("mid_pre_hs", vga2.hsync, 0);
    check("mid_pre_vs", vga2.vsync, 0);
    rst_b = 1'b1;
    #1;
    check("mid_rst_x", vga2.xpos, 14);
    check("mid_rst_y", vga2.ypos, 7);
    check("mid_rst_hs", vga2.hsync, 1);
    check("mid_rst_vs", vga2.vsync, 1);
    check("mid_rst_da", vga2.disp_active, 0);
    check("mid_rst_nl", vga2.newline, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    t = 0;
    check("mid_rel_x", vga2.xpos, 0);
    check("mid_rel_y", vga2.ypos, 0);
    check("mid_rel_nf", vga2.newframe, 1);
    check("mid_rel_da", vga2.disp_active, 1);
    check("mid_rel_vs", vga2.vsync, 1);
    step_to(10);
    check("mid_10_x", vga2.xpos, 10);
    check("mid_10_hs", vga2.hsync, 0);

`ifdef VGA_TIMING_CE_EN
    // Enable on every second edge: line period doubles, outputs hold between enables.
    rst_b = 1'b1;
    pix_ce = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    pix_ce = 1'b1;
    @(negedge clk);
    check("ce_0_x", vga2.xpos, 0);
    check("ce_0_nl", vga2.newline, 1);
    pix_ce = 1'b0;
    @(negedge clk);
    check("ce_1_x", vga2.xpos, 0);
    check("ce_1_nl", vga2.newline, 1);
    check("ce_1_nf", vga2.newframe, 1);
    for (int e = 2; e <= 31; e++) begin
      pix_ce = (e % 2 == 0);
      @(negedge clk);
      case (e)
        3: begin
          check("ce_3_x", vga2.xpos, 1);
          check("ce_3_nl", vga2.newline, 0);
        end
        21: begin
          check("ce_21_x", vga2.xpos, 10);
          check("ce_21_hs", vga2.hsync, 0);
        end
        29: check("ce_29_x", vga2.xpos, 14);
        30: begin
          check("ce_30_x", vga2.xpos, 0);
          check("ce_30_y", vga2.ypos, 1);
          check("ce_30_nl", vga2.newline, 1);
        end
        31: begin
          check("ce_31_x", vga2.xpos, 0);
          check("ce_31_nl", vga2.newline, 1);
        end
        default: ;
      endcase
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
